// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: register address width, count, ABI indices
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_COUNT  = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO = 5'd0;
   localparam reg_addr_t RA   = 5'd1;
   localparam reg_addr_t SP   = 5'd2;
   localparam reg_addr_t GP   = 5'd3;
   localparam reg_addr_t TP   = 5'd4;
   localparam reg_addr_t T0   = 5'd5;
   localparam reg_addr_t T1   = 5'd6;
   localparam reg_addr_t T2   = 5'd7;
   localparam reg_addr_t S0   = 5'd8;
   localparam reg_addr_t S1   = 5'd9;
   localparam reg_addr_t A0   = 5'd10;
   localparam reg_addr_t A1   = 5'd11;
   localparam reg_addr_t A2   = 5'd12;
   localparam reg_addr_t A3   = 5'd13;
   localparam reg_addr_t A4   = 5'd14;
   localparam reg_addr_t A5   = 5'd15;
   localparam reg_addr_t A6   = 5'd16;
   localparam reg_addr_t A7   = 5'd17;
   localparam reg_addr_t S2   = 5'd18;
   localparam reg_addr_t S3   = 5'd19;
   localparam reg_addr_t S4   = 5'd20;
   localparam reg_addr_t S5   = 5'd21;
   localparam reg_addr_t S6   = 5'd22;
   localparam reg_addr_t S7   = 5'd23;
   localparam reg_addr_t S8   = 5'd24;
   localparam reg_addr_t S9   = 5'd25;
   localparam reg_addr_t S10  = 5'd26;
   localparam reg_addr_t S11  = 5'd27;
   localparam reg_addr_t T3   = 5'd28;
   localparam reg_addr_t T4   = 5'd29;
   localparam reg_addr_t T5   = 5'd30;
   localparam reg_addr_t T6   = 5'd31;

endpackage

// File: rtl/decoder_5_to_32.sv
// rtl/decoder_5_to_32.sv - one-hot write-select decoder, all lines low when disabled
module decoder_5_to_32
   import cpu_pkg::*;
(
   input  logic                 ena,
   input  reg_addr_t            in,
   output logic [REG_COUNT-1:0] out
);

   always_comb begin
      out = '0;
      if (ena) begin
         out[in] = 1'b1;
      end
   end

endmodule

// File: rtl/register.sv
// rtl/register.sv - one enable-gated register entry with synchronous active-high reset
module register #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (ena) begin
         q <= d;
      end
   end

endmodule

// File: rtl/decoded_register_bank.sv
// rtl/decoded_register_bank.sv - 32-entry register file, 1 write / 2 read ports
// Optional X0_ZERO_EN: entry 0 is hardwired to zero with no storage behind it.
module decoded_register_bank
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_ena,
   input  reg_addr_t        wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  reg_addr_t        rd_addr0,
   output logic [WIDTH-1:0] rd_data0,
   input  reg_addr_t        rd_addr1,
   output logic [WIDTH-1:0] rd_data1
);

   logic [REG_COUNT-1:0] sel;
   logic [WIDTH-1:0]     entry [REG_COUNT];

   decoder_5_to_32 u_decoder (
      .ena (wr_ena),
      .in  (wr_addr),
      .out (sel)
   );

`ifdef X0_ZERO_EN
   // Select line 0 has no register to drive; writes to x0 simply vanish.
   logic unused_sel0;
   assign unused_sel0 = sel[0];
   assign entry[0]    = '0;
   localparam int FIRST_REG = 1;
`else
   localparam int FIRST_REG = 0;
`endif

   for (genvar i = FIRST_REG; i < REG_COUNT; i++) begin : g_entry
      register #(.WIDTH(WIDTH)) u_reg (
         .clk (clk),
         .rst (rst),
         .ena (sel[i]),
         .d   (wr_data),
         .q   (entry[i])
      );
   end

   // No write bypass: a same-cycle write shows up only after the edge.
   assign rd_data0 = entry[rd_addr0];
   assign rd_data1 = entry[rd_addr1];

`ifndef SYNTHESIS
   function automatic string abi_name(input int idx);
      if (idx == 0)       return "zero";
      else if (idx == 1)  return "ra";
      else if (idx == 2)  return "sp";
      else if (idx == 3)  return "gp";
      else if (idx == 4)  return "tp";
      else if (idx <= 7)  return $sformatf("t%0d", idx - 5);
      else if (idx <= 9)  return $sformatf("s%0d", idx - 8);
      else if (idx <= 17) return $sformatf("a%0d", idx - 10);
      else if (idx <= 27) return $sformatf("s%0d", idx - 16);
      else                return $sformatf("t%0d", idx - 25);
   endfunction

   task print_state();
      for (int i = 0; i < REG_COUNT; i++) begin
         $display("x%0d %-4s = 0x%h (%0d)", i, abi_name(i), entry[i], entry[i]);
      end
   endtask
`endif

endmodule

// File: tb/tb_decoded_register_bank.sv
// tb/tb_decoded_register_bank.sv - self-checking bench for decoded_register_bank
module tb_decoded_register_bank;

   localparam int W = 32;
`ifdef X0_ZERO_EN
   localparam bit          X0_ON  = 1'b1;
   localparam logic [31:0] X0_EXP = 32'h0;
`else
   localparam bit          X0_ON  = 1'b0;
   localparam logic [31:0] X0_EXP = 32'hCAFEF00D;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_ena;
   logic [4:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic [4:0]    rd_addr0;
   logic [W-1:0]  rd_data0;
   logic [4:0]    rd_addr1;
   logic [W-1:0]  rd_data1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model [32];

   always #5 clk = ~clk;

   decoded_register_bank #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_ena   (wr_ena),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr0 (rd_addr0),
      .rd_data0 (rd_data0),
      .rd_addr1 (rd_addr1),
      .rd_data1 (rd_data1)
   );

   typedef struct {
      logic        rst;
      logic        wr_ena;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic [4:0]  rd_addr0;
      logic [4:0]  rd_addr1;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Advance one edge; the reference model applies the register-file rules to
   // whatever inputs were presented at that edge.
   task automatic tick();
      logic       r, we;
      logic [4:0] a;
      logic [31:0] d;
      r = rst; we = wr_ena; a = wr_addr; d = wr_data;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (we && !(X0_ON && a == 5'd0)) begin
         model[a] = d;
      end
      #1;
   endtask

   task automatic check_all_vs_model(input string name);
      for (int i = 0; i < 32; i++) begin
         rd_addr0 = 5'(i);
         rd_addr1 = 5'(31 - i);
         #1;
         check({name, "_p0"}, rd_data0, model[i]);
         check({name, "_p1"}, rd_data1, model[31 - i]);
      end
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 5'd7, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 5'd31, 32'h12345678, 5'd7, 5'd31, 32'hDEADBEEF, 32'h12345678};
      vecs[2] = '{1'b0, 1'b0, 5'd7,  32'h00000000, 5'd7, 5'd31, 32'hDEADBEEF, 32'h12345678};
      vecs[3] = '{1'b0, 1'b1, 5'd3,  32'h11111111, 5'd3, 5'd7,  32'h11111111, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 1'b1, 5'd0,  32'hCAFEF00D, 5'd0, 5'd3,  X0_EXP,       32'h11111111};
      vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 5'd0, 5'd0,  X0_EXP,       X0_EXP};

      rst = 1'b0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      for (int i = 0; i < 32; i++) model[i] = 'x;
      @(negedge clk);

      // Reset wins over a simultaneous write
      rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFFFFFF;
      tick();
      rst = 1'b0; wr_ena = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd_addr0 = 5'(i);
         rd_addr1 = 5'(i);
         #1;
         check("reset_p0", rd_data0, 32'h0);
         check("reset_p1", rd_data1, 32'h0);
      end

      for (int v = 0; v < 6; v++) begin
         rst = vecs[v].rst; wr_ena = vecs[v].wr_ena;
         wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
         rd_addr0 = vecs[v].rd_addr0; rd_addr1 = vecs[v].rd_addr1;
         tick();
         check($sformatf("vec%0d_p0", v), rd_data0, vecs[v].exp0);
         check($sformatf("vec%0d_p1", v), rd_data1, vecs[v].exp1);
      end
      wr_ena = 1'b0;
      check_all_vs_model("after_table");

      // Read-during-write returns the old value until the edge
      wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h22222222; rd_addr0 = 5'd3;
      #1;
      check("rdw_before", rd_data0, 32'h11111111);
      tick();
      wr_ena = 1'b0;
      check("rdw_after", rd_data0, 32'h22222222);

      // A reset pulse that falls before the edge must do nothing
      rd_addr0 = 5'd7;
      rst = 1'b1;
      #2;
      check("rst_between_edges_comb", rd_data0, 32'hDEADBEEF);
      rst = 1'b0;
      tick();
      check("rst_between_edges", rd_data0, 32'hDEADBEEF);

      // Decoder exhaustive: every entry holds its own value
      for (int a = 0; a < 32; a++) begin
         wr_ena = 1'b1; wr_addr = 5'(a); wr_data = 32'(a) + 32'h100;
         tick();
      end
      wr_ena = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rd_addr0 = 5'(a);
         rd_addr1 = 5'(a);
         #1;
         check($sformatf("decode_%0d_p0", a), rd_data0,
               (X0_ON && a == 0) ? 32'h0 : 32'(a) + 32'h100);
         check($sformatf("decode_%0d_p1", a), rd_data1,
               (X0_ON && a == 0) ? 32'h0 : 32'(a) + 32'h100);
      end

      // Random traffic, reads checked before each edge against the model
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 39) == 0);
         wr_ena   = $urandom_range(0, 1) == 1;
         wr_addr  = 5'($urandom_range(0, 31));
         wr_data  = $urandom;
         rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr1 = 5'($urandom_range(0, 31));
         #1;
         check("rand_p0", rd_data0, model[rd_addr0]);
         check("rand_p1", rd_data1, model[rd_addr1]);
         tick();
      end
      rst = 1'b0; wr_ena = 1'b0;
      check_all_vs_model("after_rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
